// File: rtl/regfile_sequencer.sv
// regfile_sequencer
//   Multi-cycle controller that executes one instruction at a time against an
//   external 16-entry register file with a single combinational read port and
//   one write port. Each operand is read in its own cycle. The result comes
//   from an internal ALU and is written back through the same address bus.
//
// Build option:
//   CTRL_MUL_EN  defined   -> MUL is executed (low DATA_W bits of product).
//                undefined -> MUL is rejected in one cycle with err+done and
//                             no write. No multiplier is built.
//
// Ports:
//   clock        in   single clock, rising edge
//   reset        in   synchronous, active-low
//   instr_in     in   {opcode[2:0], dest, src1, imm}; src2 = imm[ADDR_W-1:0]
//   instr_valid  in   instruction present
//   instr_ready  out  high only in IDLE; transfer on valid & ready
//   rf_addr      out  register file read/write index
//   rf_rdata     in   combinational read data for rf_addr
//   rf_we        out  one-cycle write strobe
//   rf_wdata     out  write data
//   rf_clear     out  one-cycle clear-all strobe
//   disp_value   out  last DISPLAY value, held
//   disp_addr    out  register index of disp_value, held
//   disp_valid   out  one-cycle pulse when disp_value updates
//   done         out  one-cycle pulse on the final cycle of each instruction
//   err          out  one-cycle pulse for an unsupported opcode
module regfile_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int IMM_W  = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [2+2*ADDR_W+IMM_W:0]     instr_in,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  output logic [ADDR_W-1:0]             rf_addr,
  input  logic [DATA_W-1:0]             rf_rdata,
  output logic                          rf_we,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic                          rf_clear,
  output logic [DATA_W-1:0]             disp_value,
  output logic [ADDR_W-1:0]             disp_addr,
  output logic                          disp_valid,
  output logic                          done,
  output logic                          err
);

  localparam int IW = 3 + 2*ADDR_W + IMM_W;

  typedef enum logic [2:0] {
    OP_LOAD, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_CLEAR, OP_DISP
  } opcode_t;

  // ERR is only reachable when the multiplier is not built.
  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, EXEC, WRITE, CLR, DISP, ERR
  } state_t;

  state_t            r_state, w_next;
  logic [IW-1:0]     r_instr;
  logic [DATA_W-1:0] r_op_a, r_op_b, r_result;
  logic [DATA_W-1:0] r_disp_value;
  logic [ADDR_W-1:0] r_disp_addr;

  opcode_t           w_in_op, w_op;
  logic [ADDR_W-1:0] w_dest, w_src1, w_src2;
  logic [IMM_W-1:0]  w_imm;
  logic [DATA_W-1:0] w_imm_z, w_alu;

  assign w_in_op = opcode_t'(instr_in[IW-1 -: 3]);
  assign w_op    = opcode_t'(r_instr[IW-1 -: 3]);
  assign w_dest  = r_instr[IW-4 -: ADDR_W];
  assign w_src1  = r_instr[ADDR_W+IMM_W-1 -: ADDR_W];
  assign w_imm   = r_instr[IMM_W-1:0];
  assign w_src2  = w_imm[ADDR_W-1:0];
  assign w_imm_z = {{(DATA_W-IMM_W){1'b0}}, w_imm};

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = r_op_a + r_op_b;
      OP_ADDI: w_alu = r_op_a + w_imm_z;
      OP_SUB:  w_alu = r_op_a - r_op_b;
      OP_SUBI: w_alu = r_op_a - w_imm_z;
`ifdef CTRL_MUL_EN
      OP_MUL:  w_alu = r_op_a * r_op_b;
`endif
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_instr      <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_result     <= '0;
      r_disp_value <= '0;
      r_disp_addr  <= '0;
    end else begin
      if (r_state == IDLE && instr_valid) r_instr <= instr_in;
      if (r_state == RD_A) r_op_a <= rf_rdata;
      if (r_state == RD_B) r_op_b <= rf_rdata;
      if (r_state == EXEC) r_result <= w_alu;
      if (r_state == DISP) begin
        r_disp_value <= r_op_a;
        r_disp_addr  <= w_src1;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    rf_addr     = w_src1;
    rf_we       = 1'b0;
    rf_wdata    = (w_op == OP_LOAD) ? w_imm_z : r_result;
    rf_clear    = 1'b0;
    done        = 1'b0;
    disp_valid  = 1'b0;
    err         = 1'b0;
    // Outside DISP the held registers drive the display. In DISP the new
    // value is forwarded so that it appears together with disp_valid.
    disp_value  = r_disp_value;
    disp_addr   = r_disp_addr;
    case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          case (w_in_op)
            OP_LOAD:  w_next = WRITE;
            OP_CLEAR: w_next = CLR;
`ifndef CTRL_MUL_EN
            OP_MUL:   w_next = ERR;
`endif
            default:  w_next = RD_A;
          endcase
        end
      end
      RD_A: begin
        case (w_op)
          OP_DISP:          w_next = DISP;
          OP_ADDI, OP_SUBI: w_next = EXEC;
          default:          w_next = RD_B;
        endcase
      end
      RD_B: begin
        rf_addr = w_src2;
        w_next  = EXEC;
      end
      EXEC: w_next = WRITE;
      WRITE: begin
        rf_addr = w_dest;
        rf_we   = 1'b1;
        done    = 1'b1;
        w_next  = IDLE;
      end
      CLR: begin
        rf_clear = 1'b1;
        done     = 1'b1;
        w_next   = IDLE;
      end
      DISP: begin
        disp_value = r_op_a;
        disp_addr  = w_src1;
        disp_valid = 1'b1;
        done       = 1'b1;
        w_next     = IDLE;
      end
      ERR: begin
        done   = 1'b1;
`ifndef CTRL_MUL_EN
        err    = 1'b1;
`endif
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Testbench for regfile_sequencer with a behavioural stub register file.
module tb_regfile_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  rf_addr;
  logic [15:0] rf_rdata;
  logic        rf_we;
  logic [15:0] rf_wdata;
  logic        rf_clear;
  logic [15:0] disp_value;
  logic [3:0]  disp_addr;
  logic        disp_valid;
  logic        done;
  logic        err;

  logic        pre_we;
  logic [3:0]  pre_addr;
  logic [15:0] pre_data;
  logic [15:0] mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  regfile_sequencer #(.DATA_W(16), .ADDR_W(4), .IMM_W(5)) dut (
    .clock(clock), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_clear(rf_clear),
    .disp_value(disp_value), .disp_addr(disp_addr), .disp_valid(disp_valid),
    .done(done), .err(err)
  );

  // Stub register file: combinational read, clear > write > bench preload.
  always @(posedge clock) begin
    if (rf_clear) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (rf_we) begin
      mem[rf_addr] <= rf_wdata;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
  end
  assign rf_rdata = mem[rf_addr];

  typedef struct {
    string       name;
    logic [15:0] instr;
    int          lat;
    int          nwe;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    int          nclr;
    int          ndisp;
    int          nerr;
    logic [15:0] dv;
    logic [3:0]  da;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [3:0] d,
                                      input logic [3:0] s, input logic [4:0] imm);
    return {op, d, s, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    @(negedge clock);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clock);
    #1 pre_we = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " ready"},      32'(instr_ready), 32'd1);
    chk({tag, " rf_we"},      32'(rf_we),       32'd0);
    chk({tag, " rf_clear"},   32'(rf_clear),    32'd0);
    chk({tag, " done"},       32'(done),        32'd0);
    chk({tag, " disp_valid"}, 32'(disp_valid),  32'd0);
    chk({tag, " err"},        32'(err),         32'd0);
    chk({tag, " disp_value"}, 32'(disp_value),  32'd0);
    chk({tag, " disp_addr"},  32'(disp_addr),   32'd0);
    chk({tag, " rf_addr"},    32'(rf_addr),     32'd0);
    chk({tag, " rf_wdata"},   32'(rf_wdata),    32'd0);
  endtask

  // Waits (bounded) for ready at a falling edge and hands over one instruction.
  task automatic start(input string nm, input logic [15:0] ins);
    int w;
    w = 0;
    @(negedge clock);
    while (!instr_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    chk({nm, " ready wait"}, 32'(instr_ready), 32'd1);
    instr_in = ins;
    instr_valid = 1'b1;
    @(posedge clock);
    #1 instr_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat, nwe, nclr, ndisp, nerr, nrdy;
    logic [3:0]  wa;
    logic [15:0] wd;
    lat = 0; nwe = 0; nclr = 0; ndisp = 0; nerr = 0; nrdy = 0;
    wa = '0; wd = '0;
    start(v.name, v.instr);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (rf_we) begin nwe++; wa = rf_addr; wd = rf_wdata; end
      if (rf_clear) nclr++;
      if (disp_valid) ndisp++;
      if (err) nerr++;
      if (instr_ready) nrdy++;
      if (done) begin lat = k; break; end
      @(posedge clock);
    end
    chk({v.name, " latency"},    32'(lat),   32'(v.lat));
    chk({v.name, " we count"},   32'(nwe),   32'(v.nwe));
    if (v.nwe > 0) begin
      chk({v.name, " waddr"},    32'(wa),    32'(v.waddr));
      chk({v.name, " wdata"},    32'(wd),    32'(v.wdata));
    end
    chk({v.name, " clr count"},  32'(nclr),  32'(v.nclr));
    chk({v.name, " disp count"}, 32'(ndisp), 32'(v.ndisp));
    chk({v.name, " err count"},  32'(nerr),  32'(v.nerr));
    chk({v.name, " busy ready"}, 32'(nrdy),  32'd0);
    chk({v.name, " disp_value"}, 32'(disp_value), 32'(v.dv));
    chk({v.name, " disp_addr"},  32'(disp_addr),  32'(v.da));
  endtask

  initial begin
    vec_t v;
    int   nwe_abort;

    vecs[0] = '{"LOAD R3,21",     enc(3'd0, 4'd3,  4'd0, 5'd21), 1, 1, 4'd3,  16'h0015, 0, 0, 0, 16'h0000, 4'd0};
    vecs[1] = '{"ADD R4,R1,R2",   enc(3'd1, 4'd4,  4'd1, 5'd2),  4, 1, 4'd4,  16'h0010, 0, 0, 0, 16'h0000, 4'd0};
    vecs[2] = '{"SUBI R5,R0,1",   enc(3'd4, 4'd5,  4'd0, 5'd1),  3, 1, 4'd5,  16'hFFFF, 0, 0, 0, 16'h0000, 4'd0};
    vecs[3] = '{"DISPLAY R4",     enc(3'd7, 4'd0,  4'd4, 5'd0),  2, 0, 4'd0,  16'h0000, 0, 1, 0, 16'h0010, 4'd4};
    vecs[4] = '{"LOAD R8,31",     enc(3'd0, 4'd8,  4'd0, 5'd31), 1, 1, 4'd8,  16'h001F, 0, 0, 0, 16'h0010, 4'd4};
    vecs[5] = '{"ADDI R9,R3,10",  enc(3'd2, 4'd9,  4'd3, 5'd10), 3, 1, 4'd9,  16'h001F, 0, 0, 0, 16'h0010, 4'd4};
    vecs[6] = '{"SUB R10,R0,R3",  enc(3'd3, 4'd10, 4'd0, 5'd3),  4, 1, 4'd10, 16'hFFEB, 0, 0, 0, 16'h0010, 4'd4};
    vecs[7] = '{"ADD R3,R3,R3",   enc(3'd1, 4'd3,  4'd3, 5'd3),  4, 1, 4'd3,  16'h002A, 0, 0, 0, 16'h0010, 4'd4};

    reset = 1'b0; instr_valid = 1'b0; instr_in = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    // Two cycles of reset, then outputs must be at their reset values.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset("reset");
    reset = 1'b1;

    for (int i = 0; i < 16; i++) preload(4'(i), 16'h0000);
    preload(4'd1, 16'd7);
    preload(4'd2, 16'd9);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // MUL of 0x0100 * 0x0100: the product's low half is zero.
    preload(4'd1, 16'h0100);
    preload(4'd2, 16'h0100);
`ifdef CTRL_MUL_EN
    v = '{"MUL R6,R1,R2", enc(3'd5, 4'd6, 4'd1, 5'd2), 4, 1, 4'd6, 16'h0000, 0, 0, 0, 16'h0010, 4'd4};
`else
    v = '{"MUL R6,R1,R2", enc(3'd5, 4'd6, 4'd1, 5'd2), 1, 0, 4'd0, 16'h0000, 0, 0, 1, 16'h0010, 4'd4};
`endif
    run_vec(v);

    v = '{"CLEAR", enc(3'd6, 4'd0, 4'd0, 5'd0), 1, 0, 4'd0, 16'h0000, 1, 0, 0, 16'h0010, 4'd4};
    run_vec(v);
    @(negedge clock);
    chk("clear wiped R1", 32'(mem[1]), 32'd0);

    // dest equal to both sources.
    preload(4'd7, 16'd3);
    preload(4'd11, 16'h1234);
    v = '{"ADD R7,R7,R7", enc(3'd1, 4'd7, 4'd7, 5'd7), 4, 1, 4'd7, 16'h0006, 0, 0, 0, 16'h0010, 4'd4};
    run_vec(v);

    // Reset during RD_B of an ADD aborts it without any write.
    nwe_abort = 0;
    start("abort ADD", enc(3'd1, 4'd11, 4'd7, 5'd7));
    @(negedge clock);
    if (rf_we) nwe_abort++;
    chk("abort RD_A addr", 32'(rf_addr), 32'd7);
    @(posedge clock);
    @(negedge clock);
    if (rf_we) nwe_abort++;
    chk("abort RD_B ready", 32'(instr_ready), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk_reset("abort");
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (rf_we) nwe_abort++;
    end
    chk("abort no write", 32'(nwe_abort), 32'd0);
    chk("abort R11 kept", 32'(mem[11]), 32'h1234);

    // Sequencer is usable again after the abort.
    v = '{"LOAD R12,5", enc(3'd0, 4'd12, 4'd0, 5'd5), 1, 1, 4'd12, 16'h0005, 0, 0, 0, 16'h0000, 4'd0};
    run_vec(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

- Multi-cycle control FSM that executes one instruction at a time against the 16×16-bit register file, which has one combinational read port and one write port.
- Accepts an instruction through a valid/ready handshake and decodes it.
- Issues one register-file read per cycle for each operand, computes the result in an internal ALU, and writes it back. Also drives the register-file clear and display paths.
- Sits between the instruction source (switches/testbench) and the register file, so the register file never needs two read ports.

## Interface
Parameters:
- DATA_W, 16, register/ALU data width
- ADDR_W, 4, register index width (16 registers)
- IMM_W, 5, immediate width; instruction width = 3 + 2·ADDR_W + IMM_W (16 by default)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising clock
- instr_in  in  16  [15:13] opcode, [12:9] dest, [8:5] src1, [4:0] imm (src2 = [3:0])
- instr_valid  in  1  instruction present
- instr_ready  out  1  high only in IDLE; transfer when valid&ready
- rf_addr  out  ADDR_W  register file read/write index
- rf_rdata  in  DATA_W  combinational read data for rf_addr
- rf_we  out  1  write strobe, one cycle
- rf_wdata  out  DATA_W  write data
- rf_clear  out  1  clear-all strobe, one cycle
- disp_value  out  DATA_W  last DISPLAY value, held
- disp_addr  out  ADDR_W  register index of disp_value, held
- disp_valid  out  1  one-cycle pulse when disp_value updates
- done  out  1  one-cycle pulse on the final cycle of each instruction
- err  out  1  one-cycle pulse for an unsupported opcode

## Operation
Opcodes:
- 000 LOAD: dest ← zero-extended imm
- 001 ADD: dest ← src1 + src2
- 010 ADDI: dest ← src1 + zext(imm)
- 011 SUB: dest ← src1 − src2
- 100 SUBI: dest ← src1 − zext(imm)
- 101 MUL: dest ← low DATA_W bits of src1 × src2
- 110 CLEAR
- 111 DISPLAY src1

Arithmetic rules:
- All results are modulo 2^DATA_W; no flags.
- SUB wraps in two's complement (0 − 1 = 0xFFFF).

States: IDLE, RD_A, RD_B, EXEC, WRITE, CLR, DISP.

Transitions:
- IDLE: instr_ready = 1. On handshake, latch instr_in.
  - LOAD → WRITE
  - CLEAR → CLR
  - DISPLAY, ADDI, SUBI, ADD, SUB, MUL → RD_A
- RD_A: rf_addr = src1; op_a ← rf_rdata at the edge.
  - DISPLAY → DISP
  - ADDI/SUBI → EXEC
  - ADD/SUB/MUL → RD_B
- RD_B: rf_addr = src2; op_b ← rf_rdata → EXEC.
- EXEC: result register ← ALU(op_a, op_b or zext(imm)) → WRITE.
- WRITE: rf_addr = dest, rf_we = 1, rf_wdata = result (imm for LOAD), done = 1 → IDLE.
- CLR: rf_clear = 1, done = 1 → IDLE.
- DISP: disp_value ← op_a, disp_addr ← src1, disp_valid = 1, done = 1 → IDLE.

Boundary behaviour:
- instr_valid while busy: ignored (instr_ready low); the instruction must be held by the source.
- dest equal to src1 and/or src2: correct, because operands are captured before WRITE.
- rf_addr outside RD_A/RD_B/WRITE: holds src1 of the latched instruction (don't-care to the register file).

## Timing
Latency, counted in cycles from the handshake edge to the done cycle inclusive:
- LOAD: 1
- CLEAR: 1
- DISPLAY: 2
- ADDI/SUBI: 3
- ADD/SUB/MUL: 4
- Throughput: next instruction accepted the cycle after done (back-to-back valid allowed).

Reset values (reset = 0 at a rising edge):
- State → IDLE.
- rf_we, rf_clear, done, disp_valid, err → 0.
- disp_value, disp_addr, rf_addr, rf_wdata → 0.
- instr_ready is 1 the following cycle.

Reset mid-instruction:
- Aborts the instruction; no write is issued.
- The register file is NOT cleared by this block's reset.

## Configuration
- CTRL_MUL_EN defined: MUL executes as specified; err is tied 0.
- CTRL_MUL_EN undefined: MUL takes IDLE → WRITE-free path of 1 cycle, asserting err = 1 and done = 1 with no rf_we; no multiplier is synthesized.

## Test plan
- Reset held low 2 cycles, then LOAD R3, imm 21 → rf_we one cycle after handshake, rf_addr = 3, rf_wdata = 0x0015, done coincident.
- Preload R1 = 7, R2 = 9 (via stub register file); ADD R4, R1, R2 → reads of addr 1 then 2, write R4 = 16 exactly 4 cycles after handshake; instr_ready low for cycles 1–4.
- SUBI R5, R0(=0), imm 1 → R5 = 0xFFFF; MUL R6, R1(=0x0100), R2(=0x0100) → R6 = 0x0000 (with CTRL_MUL_EN), or err pulse and no write (without it).
- DISPLAY R4 → disp_valid pulse 2 cycles after handshake, disp_value = 16, disp_addr = 4; value held through following LOAD.
- CLEAR → rf_clear single-cycle pulse with done; then ADD R7, R7, R7 with R7 = 3 → R7 = 6 (dest = source).
- Assert reset low in the RD_B cycle of an ADD → no rf_we ever issued for it; next cycle IDLE with all outputs at reset values.
